// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 S-box sequencer.
//   - FSM state encodings (IDLE .. PR_HOLD)
//   - KSA_LAST: index of the final key-scheduling swap
//   - SBOX_DEPTH / IDX_W: S-box size and the width of the i/j indices
package rc4_pkg;

  typedef logic [2:0] rc4_state_t;

  localparam rc4_state_t IDLE    = 3'd0;
  localparam rc4_state_t INIT    = 3'd1;
  localparam rc4_state_t KSA_RD  = 3'd2;
  localparam rc4_state_t KSA_SW  = 3'd3;
  localparam rc4_state_t PR_RD   = 3'd4;
  localparam rc4_state_t PR_SW   = 3'd5;
  localparam rc4_state_t PR_OUT  = 3'd6;
  localparam rc4_state_t PR_HOLD = 3'd7;

  localparam int unsigned SBOX_DEPTH = 256;
  localparam int unsigned IDX_W      = $clog2(SBOX_DEPTH);

  localparam logic [IDX_W-1:0] KSA_LAST = 8'd255;

endpackage

// File: rtl/rc4_key_sel.sv
// Key byte selector: picks byte kidx out of the captured key.
// Ports:
//   key      in  KEY_BYTES*8  captured key, byte n at key[n*8+:8]
//   kidx     in  KLW          byte index (always < KEY_BYTES in use)
//   key_byte out 8            selected byte, 0 for an out-of-range index
module rc4_key_sel
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = 16,
  parameter int KLW       = 5
) (
  input  logic [KEY_BYTES*8-1:0] key,
  input  logic [KLW-1:0]         kidx,
  output logic [7:0]             key_byte
);

  always_comb begin
    key_byte = '0;
    for (int n = 0; n < KEY_BYTES; n++) begin
      if (kidx == KLW'(n)) key_byte = key[n*8 +: 8];
    end
  end

endmodule

// File: rtl/rc4_sbox_ctrl.sv
// RC4 sequencer driving an external 3-port S-box RAM.
// Resets the RAM to identity, runs KSA with the read port plus paired swap
// writes, then runs PRGA and streams keystream bytes on a valid/ready port.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, stop       session start (IDLE only) / abort to IDLE
//   key, key_len      key bytes and length (0 -> 1, >KEY_BYTES -> KEY_BYTES)
//   busy              high outside IDLE
//   ks_valid/ready    keystream handshake, ks_byte is the data
//   mem_rst_n         RAM reset (low restores S[x]=x)
//   mem_raddr/rdata   RAM read port 1 (combinational read)
//   mem_waddr/wdata   RAM write port 2
//   mem_addr/wdata3/rdata3  RAM read/write port 3
//   mem_wen           common write enable for ports 2 and 3
module rc4_sbox_ctrl
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = 16,
  parameter int KLW       = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  input  logic [KEY_BYTES*8-1:0] key,
  input  logic [KLW-1:0]         key_len,
  output logic                   busy,
  output logic                   ks_valid,
  input  logic                   ks_ready,
  output logic [7:0]             ks_byte,
  output logic                   mem_rst_n,
  output logic [7:0]             mem_raddr,
  input  logic [7:0]             mem_rdata,
  output logic [7:0]             mem_waddr,
  output logic [7:0]             mem_wdata,
  output logic [7:0]             mem_addr,
  output logic [7:0]             mem_wdata3,
  input  logic [7:0]             mem_rdata3,
  output logic                   mem_wen
);

  rc4_state_t             state_q, state_d;
  logic [IDX_W-1:0]       i_q, i_d;
  logic [IDX_W-1:0]       j_q, j_d;
  logic [7:0]             si_q, si_d;
  logic [7:0]             t_q, t_d;
  logic [KLW-1:0]         kidx_q, kidx_d;
  logic [KLW-1:0]         klen_q, klen_d;
  logic [KEY_BYTES*8-1:0] key_q, key_d;
  logic                   ks_valid_q, ks_valid_d;
  logic [7:0]             ks_byte_q, ks_byte_d;

  logic [KLW-1:0]         klen_in;
  logic [7:0]             key_byte;

  rc4_key_sel #(
    .KEY_BYTES(KEY_BYTES),
    .KLW      (KLW)
  ) u_key_sel (
    .key     (key_q),
    .kidx    (kidx_q),
    .key_byte(key_byte)
  );

  always_comb begin
    if (key_len == '0)                      klen_in = KLW'(1);
    else if (key_len > KLW'(KEY_BYTES))     klen_in = KLW'(KEY_BYTES);
    else                                    klen_in = key_len;
  end

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    si_d       = si_q;
    t_d        = t_q;
    kidx_d     = kidx_q;
    klen_d     = klen_q;
    key_d      = key_q;
    ks_valid_d = ks_valid_q;
    ks_byte_d  = ks_byte_q;
    mem_raddr  = '0;
    mem_waddr  = '0;
    mem_wdata  = '0;
    mem_addr   = '0;
    mem_wdata3 = '0;
    mem_wen    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          key_d   = key;
          klen_d  = klen_in;
          i_d     = '0;
          j_d     = '0;
          kidx_d  = '0;
          state_d = INIT;
        end
      end
      INIT: begin
        i_d     = '0;
        state_d = KSA_RD;
      end
      KSA_RD: begin
        mem_raddr = i_q;
        si_d      = mem_rdata;
        j_d       = j_q + mem_rdata + key_byte;
        kidx_d    = (kidx_q == klen_q - KLW'(1)) ? '0 : kidx_q + KLW'(1);
        state_d   = KSA_SW;
      end
      KSA_SW: begin
        // i==j needs no special case: both ports then write si to one address.
        mem_addr   = j_q;
        mem_waddr  = i_q;
        mem_wdata  = mem_rdata3;
        mem_wdata3 = si_q;
        mem_wen    = 1'b1;
        if (i_q == KSA_LAST) begin
          i_d     = '0;
          j_d     = '0;
          state_d = PR_RD;
        end else begin
          i_d     = i_q + 8'd1;
          state_d = KSA_RD;
        end
      end
      PR_RD: begin
        i_d       = i_q + 8'd1;
        mem_raddr = i_q + 8'd1;
        si_d      = mem_rdata;
        j_d       = j_q + mem_rdata;
        state_d   = PR_SW;
      end
      PR_SW: begin
        mem_addr   = j_q;
        mem_waddr  = i_q;
        mem_wdata  = mem_rdata3;
        mem_wdata3 = si_q;
        mem_wen    = 1'b1;
        t_d        = si_q + mem_rdata3;
        state_d    = PR_OUT;
      end
      PR_OUT: begin
        // Read happens after the swap edge, so this sees post-swap contents.
        mem_raddr  = t_q;
        ks_byte_d  = mem_rdata;
        ks_valid_d = 1'b1;
        state_d    = PR_HOLD;
      end
      PR_HOLD: begin
        if (ks_valid_q && ks_ready) begin
          ks_valid_d = 1'b0;
          state_d    = PR_RD;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides every transition, including a pending handshake.
    if (stop && state_q != IDLE) begin
      state_d    = IDLE;
      ks_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      i_q        <= '0;
      j_q        <= '0;
      si_q       <= '0;
      t_q        <= '0;
      kidx_q     <= '0;
      klen_q     <= KLW'(1);
      key_q      <= '0;
      ks_valid_q <= 1'b0;
      ks_byte_q  <= '0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      si_q       <= si_d;
      t_q        <= t_d;
      kidx_q     <= kidx_d;
      klen_q     <= klen_d;
      key_q      <= key_d;
      ks_valid_q <= ks_valid_d;
      ks_byte_q  <= ks_byte_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign ks_valid  = ks_valid_q;
  assign ks_byte   = ks_byte_q;
  assign mem_rst_n = ~(rst | (state_q == INIT));

endmodule

// File: tb/tb_rc4_sbox_ctrl.sv
// Directed bench for rc4_sbox_ctrl with a behavioural 3-port S-box RAM.
module tb_rc4_sbox_ctrl;

  logic         clk = 1'b0;
  logic         rst, start, stop, ks_ready;
  logic [127:0] key;
  logic [4:0]   key_len;
  logic         busy, ks_valid, mem_rst_n, mem_wen;
  logic [7:0]   ks_byte, mem_raddr, mem_rdata, mem_waddr, mem_wdata;
  logic [7:0]   mem_addr, mem_wdata3, mem_rdata3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rc4_sbox_ctrl #(.KEY_BYTES(16), .KLW(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .key       (key),
    .key_len   (key_len),
    .busy      (busy),
    .ks_valid  (ks_valid),
    .ks_ready  (ks_ready),
    .ks_byte   (ks_byte),
    .mem_rst_n (mem_rst_n),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .mem_addr  (mem_addr),
    .mem_wdata3(mem_wdata3),
    .mem_rdata3(mem_rdata3),
    .mem_wen   (mem_wen)
  );

  // S-box RAM model: synchronous reset to identity, two write ports on one wen.
  logic [7:0] sbox [256];
  assign mem_rdata  = sbox[mem_raddr];
  assign mem_rdata3 = sbox[mem_addr];

  always @(posedge clk) begin
    if (!mem_rst_n) begin
      for (int x = 0; x < 256; x++) sbox[x] <= 8'(x);
    end else if (mem_wen) begin
      sbox[mem_waddr] <= mem_wdata;
      sbox[mem_addr]  <= mem_wdata3;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_byte(output logic [7:0] b, output int gap);
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (!ks_valid && gap < 1000);
    b = ks_byte;
  endtask

  task automatic start_session(input string tag, input logic [127:0] k, input logic [4:0] kl);
    int n;
    key = k; key_len = kl; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " init_rst_n"}, mem_rst_n, 1'b0);
    chk({tag, " busy"}, busy, 1'b1);
    @(negedge clk);
    chk({tag, " rst_n_release"}, mem_rst_n, 1'b1);
    n = 1;
    while (!ks_valid && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " latency"}, n, 516);
  endtask

  // Expected bytes packed first-byte-most-significant in v, n of them.
  task automatic expect_stream(input string tag, input logic [127:0] v, input int n);
    logic [7:0] b;
    int gap;
    chk({tag, " b0"}, ks_byte, v[(n-1)*8 +: 8]);
    for (int k = 1; k < n; k++) begin
      next_byte(b, gap);
      chk($sformatf("%s gap%0d", tag, k), gap, 4);
      chk($sformatf("%s b%0d", tag, k), b, v[(n-1-k)*8 +: 8]);
    end
  endtask

  task automatic do_stop(input string tag);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk({tag, " stop busy"}, busy, 1'b0);
    chk({tag, " stop valid"}, ks_valid, 1'b0);
    chk({tag, " stop wen"}, mem_wen, 1'b0);
  endtask

  initial begin
    logic [7:0] b;
    int gap;

    rst = 1'b1; start = 1'b0; stop = 1'b0; ks_ready = 1'b1;
    key = '0; key_len = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", busy, 1'b0);
    chk("reset valid", ks_valid, 1'b0);
    chk("reset byte", ks_byte, 8'h00);
    chk("reset wen", mem_wen, 1'b0);
    chk("reset mem_rst_n", mem_rst_n, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle mem_rst_n", mem_rst_n, 1'b1);
    chk("idle raddr", mem_raddr, 8'h00);

    // "Key"
    start_session("key", 128'h79654B, 5'd3);
    expect_stream("key", 128'hEB9F7781B734CA72A7, 9);
    do_stop("key");

    // "Wiki"
    start_session("wiki", 128'h696B6957, 5'd4);
    expect_stream("wiki", 128'h6044DB6D41B7, 6);
    do_stop("wiki");

    // "Secret"
    start_session("secret", 128'h746572636553, 5'd6);
    expect_stream("secret", 128'h04D46B053CA87B59, 8);
    do_stop("secret");

    // start and stop together in IDLE: stop wins
    key = 128'h79654B; key_len = 5'd3; start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    chk("startstop busy", busy, 1'b0);
    chk("startstop mem_rst_n", mem_rst_n, 1'b1);

    // stop during KSA, then rerun "Key" with junk above the key length
    key = 128'h79654B; key_len = 5'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (200) @(negedge clk);
    chk("ksa busy", busy, 1'b1);
    do_stop("ksa");
    start_session("rekey", 128'hDEADBEEF_01234567_89ABCDEF_0079654B, 5'd3);
    expect_stream("rekey", 128'hEB9F, 2);

    // backpressure on the third byte
    @(negedge clk);
    ks_ready = 1'b0;
    gap = 1;
    while (!ks_valid && gap < 1000) begin
      @(negedge clk);
      gap++;
    end
    chk("stall gap", gap, 4);
    chk("stall b2", ks_byte, 8'h77);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("stall hold valid%0d", c), ks_valid, 1'b1);
      chk($sformatf("stall hold byte%0d", c), ks_byte, 8'h77);
    end
    ks_ready = 1'b1;
    next_byte(b, gap);
    chk("resume gap", gap, 4);
    chk("resume b3", b, 8'h81);
    next_byte(b, gap);
    chk("resume b4", b, 8'hB7);
    do_stop("rekey");

    // key_len=0 behaves as length 1 (upper key bytes are junk)
    start_session("klen0", 128'hFFEEDDCC_BBAA9988_77665544_33221100, 5'd0);
    expect_stream("klen0", 128'hDE188941A3375D3A, 8);
    do_stop("klen0");

    // reset during PRGA, start in the reset cycle is ignored
    start_session("rstp", 128'h79654B, 5'd3);
    expect_stream("rstp", 128'hEB9F, 2);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    chk("rstp busy", busy, 1'b0);
    chk("rstp valid", ks_valid, 1'b0);
    chk("rstp mem_rst_n", mem_rst_n, 1'b0);
    chk("rstp byte", ks_byte, 8'h00);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rstp idle busy", busy, 1'b0);
    chk("rstp idle mem_rst_n", mem_rst_n, 1'b1);

    start_session("after_rst", 128'h79654B, 5'd3);
    expect_stream("after_rst", 128'hEB9F77, 3);
    do_stop("after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
